hazard_controller: RTL and testbench

Sequences the five-stage pipeline around data and control hazards. Each cycle it decides whether to hold, bubble or flush the front-end stages, and whether to freeze the whole pipeline during two-cycle memory accesses. It sits beside the ID/EX register: it computes operand-forwarding selects in decode and registers them into EX alongside the instruction. It owns the only state machine that stalls the pipeline.

---
 rtl/hazard_controller.sv | 129 ++++++++++++
 tb/tb_hazard_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: stall/bubble/flush/freeze controls and registered EX forwarding selects.
// Optional saturating stall counter enabled by defining HAZARD_STALL_COUNTER_EN.
module hazard_controller #(
    parameter int unsigned REG_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_rs_id,
    input  logic [REG_W-1:0] i_rt_id,
    input  logic             i_rs_used_id,
    input  logic             i_rt_used_id,
    input  logic [REG_W-1:0] i_rd_ex,
    input  logic             i_wb_en_ex,
    input  logic             i_mem_read_ex,
    input  logic [REG_W-1:0] i_rd_mem,
    input  logic             i_wb_en_mem,
    input  logic             i_mem_multi,
    input  logic             i_branch_taken,
    output logic             o_pc_hold,
    output logic             o_ifid_hold,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_freeze,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
`ifdef HAZARD_STALL_COUNTER_EN
    output logic [CNT_W-1:0] o_stall_cnt,
`endif
    output logic [1:0]       o_state
);

    localparam int unsigned FWD_W = 2;
    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MWB = 2'b10;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic             load_use;
    logic [FWD_W-1:0] fwd_a_nxt, fwd_b_nxt;

    // Decode-stage dependency detection against EX and MEM destinations
    always_comb begin
        hit_ex_a  = i_rs_used_id & i_wb_en_ex  & (i_rs_id == i_rd_ex);
        hit_ex_b  = i_rt_used_id & i_wb_en_ex  & (i_rt_id == i_rd_ex);
        hit_mem_a = i_rs_used_id & i_wb_en_mem & (i_rs_id == i_rd_mem);
        hit_mem_b = i_rt_used_id & i_wb_en_mem & (i_rt_id == i_rd_mem);
        load_use  = i_mem_read_ex & (hit_ex_a | hit_ex_b);
        fwd_a_nxt = hit_ex_a ? FWD_EXM : (hit_mem_a ? FWD_MWB : FWD_RF);
        fwd_b_nxt = hit_ex_b ? FWD_EXM : (hit_mem_b ? FWD_MWB : FWD_RF);
    end

    // Next state and Mealy controls; MEM_WAIT ignores i_mem_multi since the same access still drives it
    always_comb begin
        state_nxt     = RUN;
        o_pc_hold     = 1'b0;
        o_ifid_hold   = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_freeze      = 1'b0;
        if ((state != MEM_WAIT) && i_mem_multi) begin
            o_freeze    = 1'b1;
            o_pc_hold   = 1'b1;
            o_ifid_hold = 1'b1;
            state_nxt   = MEM_WAIT;
        end else if (i_branch_taken) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (load_use) begin
            o_pc_hold     = 1'b1;
            o_ifid_hold   = 1'b1;
            o_idex_bubble = 1'b1;
            state_nxt     = LOAD_STALL;
        end
        if (!i_rst_n) begin
            o_pc_hold     = 1'b0;
            o_ifid_hold   = 1'b0;
            o_ifid_flush  = 1'b0;
            o_idex_bubble = 1'b0;
            o_freeze      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Forwarding selects travel with the instruction into EX
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fwd_a <= FWD_RF;
            o_fwd_b <= FWD_RF;
        end else if (o_freeze) begin
            o_fwd_a <= o_fwd_a;
            o_fwd_b <= o_fwd_b;
        end else if (o_idex_bubble) begin
            o_fwd_a <= FWD_RF;
            o_fwd_b <= FWD_RF;
        end else begin
            o_fwd_a <= fwd_a_nxt;
            o_fwd_b <= fwd_b_nxt;
        end
    end

    assign o_state = state;

`ifdef HAZARD_STALL_COUNTER_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (o_pc_hold && (o_stall_cnt != {CNT_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized run against a reference model.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rs_id, rt_id, rd_ex, rd_mem;
    logic       rs_used, rt_used, wb_en_ex, mem_read_ex, wb_en_mem, mem_multi, branch;
    logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze;
    logic [1:0] fwd_a, fwd_b, state;
`ifdef HAZARD_STALL_COUNTER_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_W(3), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs_id(rs_id), .i_rt_id(rt_id),
        .i_rs_used_id(rs_used), .i_rt_used_id(rt_used),
        .i_rd_ex(rd_ex), .i_wb_en_ex(wb_en_ex), .i_mem_read_ex(mem_read_ex),
        .i_rd_mem(rd_mem), .i_wb_en_mem(wb_en_mem),
        .i_mem_multi(mem_multi), .i_branch_taken(branch),
        .o_pc_hold(pc_hold), .o_ifid_hold(ifid_hold), .o_ifid_flush(ifid_flush),
        .o_idex_bubble(idex_bubble), .o_freeze(freeze),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
`ifdef HAZARD_STALL_COUNTER_EN
        .o_stall_cnt(stall_cnt),
`endif
        .o_state(state)
    );

    task automatic idle_inputs();
        rs_id = 3'd0; rt_id = 3'd0; rd_ex = 3'd0; rd_mem = 3'd0;
        rs_used = 1'b0; rt_used = 1'b0; wb_en_ex = 1'b0; mem_read_ex = 1'b0;
        wb_en_mem = 1'b0; mem_multi = 1'b0; branch = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] ctl;
        apply_reset();
        // Drive everything active and let the FSM leave RUN, then reset mid-cycle
        rs_id = 3'd2; rt_id = 3'd2; rd_ex = 3'd2; rd_mem = 3'd2;
        rs_used = 1'b1; rt_used = 1'b1; wb_en_ex = 1'b1; mem_read_ex = 1'b1;
        wb_en_mem = 1'b1; mem_multi = 1'b1; branch = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze};
        checks++; if (state !== 2'b00) $display("FAIL reset_state got=%b exp=00", state); else passed++;
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_b}); else passed++;
        checks++; if (ctl !== 5'b0) $display("FAIL reset_ctl got=%b exp=00000", ctl); else passed++;
`ifdef HAZARD_STALL_COUNTER_EN
        checks++; if (stall_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); else passed++;
`endif
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze};
        checks++; if (ctl !== 5'b0) $display("FAIL idle_ctl got=%b exp=00000", ctl); else passed++;
    endtask

    task automatic test_fwd_ex();
        idle_inputs();
        rs_id = 3'd3; rs_used = 1'b1; rd_ex = 3'd3; wb_en_ex = 1'b1;
        @(negedge clk);
        checks++; if ({pc_hold, idex_bubble} !== 2'b00) $display("FAIL fwd_ex_nostall got=%b exp=00", {pc_hold, idex_bubble}); else passed++;
        @(posedge clk);
        #1;
        idle_inputs();
        checks++; if (fwd_a !== 2'b01) $display("FAIL fwd_ex_a got=%b exp=01", fwd_a); else passed++;
        checks++; if (fwd_b !== 2'b00) $display("FAIL fwd_ex_b got=%b exp=00", fwd_b); else passed++;
    endtask

    task automatic test_load_use();
        idle_inputs();
        rd_ex = 3'd5; wb_en_ex = 1'b1; mem_read_ex = 1'b1; rt_id = 3'd5; rt_used = 1'b1;
        @(negedge clk);
        checks++; if ({pc_hold, ifid_hold, idex_bubble, freeze} !== 4'b1110)
            $display("FAIL load_use_ctl got=%b exp=1110", {pc_hold, ifid_hold, idex_bubble, freeze}); else passed++;
        @(posedge clk);
        #1;
        checks++; if (state !== 2'b01) $display("FAIL load_use_state got=%b exp=01", state); else passed++;
        // Bubble in EX, load now in MEM, consumer still in decode
        wb_en_ex = 1'b0; mem_read_ex = 1'b0; rd_ex = 3'd0; rd_mem = 3'd5; wb_en_mem = 1'b1;
        @(negedge clk);
        checks++; if ({pc_hold, idex_bubble} !== 2'b00) $display("FAIL load_use_release got=%b exp=00", {pc_hold, idex_bubble}); else passed++;
        @(posedge clk);
        #1;
        idle_inputs();
        checks++; if (fwd_b !== 2'b10) $display("FAIL load_use_fwd_b got=%b exp=10", fwd_b); else passed++;
        checks++; if (state !== 2'b00) $display("FAIL load_use_back_run got=%b exp=00", state); else passed++;
    endtask

    task automatic test_mem_multi_branch();
        idle_inputs();
        mem_multi = 1'b1; branch = 1'b1;
        @(negedge clk);
        checks++; if ({freeze, pc_hold, ifid_hold, ifid_flush, idex_bubble} !== 5'b11100)
            $display("FAIL multi_c1 got=%b exp=11100", {freeze, pc_hold, ifid_hold, ifid_flush, idex_bubble}); else passed++;
        @(posedge clk);
        #1;
        checks++; if (state !== 2'b10) $display("FAIL multi_state got=%b exp=10", state); else passed++;
        @(negedge clk);
        checks++; if ({freeze, pc_hold, ifid_hold, ifid_flush, idex_bubble} !== 5'b00011)
            $display("FAIL multi_c2 got=%b exp=00011", {freeze, pc_hold, ifid_hold, ifid_flush, idex_bubble}); else passed++;
        @(posedge clk);
        #1;
        idle_inputs();
        checks++; if (state !== 2'b00) $display("FAIL multi_return got=%b exp=00", state); else passed++;
    endtask

    task automatic test_branch_load_use();
        idle_inputs();
        rd_ex = 3'd4; wb_en_ex = 1'b1; mem_read_ex = 1'b1; rs_id = 3'd4; rs_used = 1'b1; branch = 1'b1;
        @(negedge clk);
        checks++; if ({ifid_flush, idex_bubble, pc_hold} !== 3'b110)
            $display("FAIL branch_lu_ctl got=%b exp=110", {ifid_flush, idex_bubble, pc_hold}); else passed++;
        @(posedge clk);
        #1;
        idle_inputs();
        checks++; if (state !== 2'b00) $display("FAIL branch_lu_state got=%b exp=00", state); else passed++;
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL branch_lu_fwd got=%b exp=0000", {fwd_a, fwd_b}); else passed++;
    endtask

    task automatic test_reset_mid_mem_wait();
        idle_inputs();
        mem_multi = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (state !== 2'b10) $display("FAIL rmw_enter got=%b exp=10", state); else passed++;
        branch = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'b00) $display("FAIL rmw_state got=%b exp=00", state); else passed++;
        checks++; if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze} !== 5'b0)
            $display("FAIL rmw_ctl got=%b exp=00000", {pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze}); else passed++;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference: state names as integers (0 run, 1 after load stall, 2 second beat of multi access)
    task automatic test_random();
        int          m_state;
        int          m_fa, m_fb, nst, e_fa, e_fb;
        logic [4:0]  e_ctl;
        bit          ea, eb, ma, mb, lu;
        int unsigned m_cnt;
        apply_reset();
        m_state = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
        for (int n = 0; n < 500; n++) begin
            rs_id = 3'($urandom_range(0, 3)); rt_id = 3'($urandom_range(0, 3));
            rd_ex = 3'($urandom_range(0, 3)); rd_mem = 3'($urandom_range(0, 3));
            rs_used = 1'($urandom); rt_used = 1'($urandom);
            wb_en_ex = 1'($urandom); mem_read_ex = 1'($urandom_range(0, 2) == 0);
            wb_en_mem = 1'($urandom);
            mem_multi = (m_state == 1) ? 1'b0 : 1'($urandom_range(0, 5) == 0);
            branch = 1'($urandom_range(0, 5) == 0);
            ea = rs_used && wb_en_ex && (rs_id == rd_ex);
            eb = rt_used && wb_en_ex && (rt_id == rd_ex);
            ma = rs_used && wb_en_mem && (rs_id == rd_mem);
            mb = rt_used && wb_en_mem && (rt_id == rd_mem);
            lu = mem_read_ex && (ea || eb);
            // e_ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze}
            nst = 0;
            if (m_state != 2 && mem_multi) begin
                e_ctl = 5'b11001; nst = 2;
            end else if (branch) begin
                e_ctl = 5'b00110;
            end else if (lu) begin
                e_ctl = 5'b11010; nst = 1;
            end else begin
                e_ctl = 5'b00000;
            end
            @(negedge clk);
            checks++; if (state !== 2'(m_state)) $display("FAIL rnd_state n=%0d got=%b exp=%0d", n, state, m_state); else passed++;
            checks++; if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze} !== e_ctl)
                $display("FAIL rnd_ctl n=%0d got=%b exp=%b", n, {pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze}, e_ctl); else passed++;
            checks++; if ({fwd_a, fwd_b} !== {2'(m_fa), 2'(m_fb)})
                $display("FAIL rnd_fwd n=%0d got=%b%b exp=%0d%0d", n, fwd_a, fwd_b, m_fa, m_fb); else passed++;
`ifdef HAZARD_STALL_COUNTER_EN
            checks++; if (stall_cnt !== 16'(m_cnt)) $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_cnt); else passed++;
`endif
            @(posedge clk);
            e_fa = ea ? 1 : (ma ? 2 : 0);
            e_fb = eb ? 1 : (mb ? 2 : 0);
            if (e_ctl[0]) begin
                // frozen: selects unchanged
            end else if (e_ctl[1]) begin
                m_fa = 0; m_fb = 0;
            end else begin
                m_fa = e_fa; m_fb = e_fb;
            end
            if (e_ctl[4] && m_cnt < 65535) m_cnt++;
            m_state = nst;
            #1;
        end
        idle_inputs();
    endtask

`ifdef HAZARD_STALL_COUNTER_EN
    task automatic test_stall_counter();
        apply_reset();
        rd_ex = 3'd1; wb_en_ex = 1'b1; mem_read_ex = 1'b1; rs_id = 3'd1; rs_used = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'd65535) $display("FAIL stall_cnt_sat got=%0d exp=65535", stall_cnt); else passed++;
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_mem_multi_branch();
        test_branch_load_use();
        test_reset_mid_mem_wait();
        test_random();
`ifdef HAZARD_STALL_COUNTER_EN
        test_stall_counter();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
